// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control and the ALU control decoder.
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // aluOp codes consumed by ALU_Control
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state encodings (visible on the debug port)
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_I_EXEC    = 4'd9;
    localparam logic [3:0] S_I_WB      = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;

    // Datapath control bundle decoded from the state register
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_half;
        logic       mem_unsigned;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Where DECODE goes for a given opcode; unsupported opcodes fall back to FETCH.
    function automatic logic [3:0] decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW, OP_LH, OP_LHU: return S_MEM_ADDR;
            OP_RTYPE:                    return S_R_EXEC;
            OP_ADDI, OP_ANDI, OP_ORI:    return S_I_EXEC;
            OP_BEQ:                      return S_BRANCH;
            OP_J:                        return S_JUMP;
            default:                     return S_FETCH;
        endcase
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return decode_target(op) != S_FETCH;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_timer.sv
// Memory wait counter: counts consecutive not-ready cycles in a memory-access
// state and flags a timeout on the MEM_TIMEOUT-th one.
module mips_mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam logic [7:0] TERM_COUNT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Timeout fires during the cycle that would be the MEM_TIMEOUT-th stall.
    assign timeout_o = waiting_i & ~mem_ready_i & (count_q == TERM_COUNT);

    // Clearing outside the wait states also covers the clear-on-entry case,
    // since no wait state is entered directly from another with a stall pending.
    always_comb begin
        count_d = count_q;
        if (!waiting_i || mem_ready_i || timeout_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM.
// Optional: define CTRL_INSTR_COUNT_EN to add the instrCount retired-instruction counter.
//
// state     | meaning
// IDLE      | after reset or timeout, no outputs
// FETCH     | read instruction, PC+4; IR/PC load when memReady
// DECODE    | branch target precompute, dispatch on opcode
// MEM_ADDR  | effective address rs + imm
// MEM_READ  | load access, wait for memReady
// MEM_WB    | write loaded data to rt
// MEM_WRITE | store access, wait for memReady
// R_EXEC    | R-type ALU operation
// R_WB      | write ALUOut to rd
// I_EXEC    | immediate ALU operation
// I_WB      | write ALUOut to rt
// BRANCH    | beq compare and conditional PC load
// JUMP      | PC load from jump target
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        pcWriteCond,
    output logic        iorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        memHalf,
    output logic        memUnsigned,
    output logic        irWrite,
    output logic        memToReg,
    output logic        regDst,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluOp,
    output logic [1:0]  pcSource,
    output logic        illegalOp,
    output logic        memTimeout,
`ifdef CTRL_INSTR_COUNT_EN
    output logic [31:0] instrCount,
`endif
    output logic [3:0]  state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       waiting;
    logic       mem_timeout;
    logic       is_half;
    ctrl_t      ctrl;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign is_half = (opcode == OP_LH) || (opcode == OP_LHU);

    mips_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .waiting_i  (waiting),
        .mem_ready_i(memReady),
        .timeout_o  (mem_timeout)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                if (memReady) begin
                    state_d = S_DECODE;
                end else if (mem_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE:    state_d = decode_target(opcode);
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (memReady) begin
                    state_d = S_MEM_WB;
                end else if (mem_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_MEM_WRITE: begin
                if (memReady) begin
                    state_d = S_FETCH;
                end else if (mem_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode; anything not set for a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = memReady;
                ctrl.pc_write  = memReady;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read     = 1'b1;
                ctrl.ior_d        = 1'b1;
                ctrl.mem_half     = is_half;
                ctrl.mem_unsigned = (opcode == OP_LHU);
            end
            S_MEM_WB: begin
                ctrl.reg_write    = 1'b1;
                ctrl.mem_to_reg   = 1'b1;
                ctrl.mem_half     = is_half;
                ctrl.mem_unsigned = (opcode == OP_LHU);
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ANDI: ctrl.alu_op = ALUOP_AND;
                    OP_ORI:  ctrl.alu_op = ALUOP_OR;
                    default: ctrl.alu_op = ALUOP_ADD;
                endcase
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

    assign pcWrite     = ctrl.pc_write;
    assign pcWriteCond = ctrl.pc_write_cond;
    assign iorD        = ctrl.ior_d;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign memHalf     = ctrl.mem_half;
    assign memUnsigned = ctrl.mem_unsigned;
    assign irWrite     = ctrl.ir_write;
    assign memToReg    = ctrl.mem_to_reg;
    assign regDst      = ctrl.reg_dst;
    assign regWrite    = ctrl.reg_write;
    assign aluSrcA     = ctrl.alu_src_a;
    assign aluSrcB     = ctrl.alu_src_b;
    assign aluOp       = ctrl.alu_op;
    assign pcSource    = ctrl.pc_source;
    assign illegalOp   = (state_q == S_DECODE) && !op_is_legal(opcode);
    assign memTimeout  = mem_timeout;
    assign state       = state_q;

`ifdef CTRL_INSTR_COUNT_EN
    logic [31:0] instr_count_q;
    logic        instr_done;

    // Only completing states count; illegal-opcode and timeout exits do not.
    always_comb begin
        instr_done = (state_d == S_FETCH) &&
                     ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                      (state_q == S_R_WB)   || (state_q == S_I_WB) ||
                      (state_q == S_BRANCH) || (state_q == S_JUMP));
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_q <= '0;
        end else if (instr_done) begin
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign instrCount = instr_count_q;
`endif

endmodule
